// File: rtl/ps2_keycode_writer.sv
// ps2_keycode_writer: decodes a PS/2 set-2 scan code stream into the 16-bit Hack key code of the held key.
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data raw async pins;
//   out = Hack code of held key (0 = none); key_valid = 1-cycle pulse when out is written by a make/break;
//   frame_err = 1-cycle pulse on start/stop/timeout error (and parity error when PS2_PARITY_CHECK_EN is defined).
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits are not odd parity.
module ps2_keycode_writer #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] out,
  output logic        key_valid,
  output logic        frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tmo, w_tmo;
  logic [2:0] r_cnt, w_cnt;
  logic [7:0] r_sh, w_sh, r_byte, r_out, w_code;
  logic r_clk_filt, r_par, w_par, r_byte_vld, r_shl, r_shr, r_brk, r_ext;
  logic w_clk_s, w_dat, w_flip, w_fall, w_done, w_err, w_par_ok;
  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat   = r_dat_sync[SYNC_STAGES-1];
  // filtered clock flips once FILTER_LEN consecutive samples disagree with it
  assign w_flip  = (w_clk_s != r_clk_filt) && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_fall  = w_flip && r_clk_filt;
`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_sh, r_par};
`else
  assign w_par_ok = 1'b1;
`endif
  assign out = {8'h00, r_out};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_filt <= 1'b1;
      r_fcnt     <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_filt <= w_flip ? w_clk_s : r_clk_filt;
      r_fcnt     <= (w_clk_s == r_clk_filt || w_flip) ? '0 : r_fcnt + FW'(1);
    end
  end
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_sh   = r_sh;
    w_par  = r_par;
    w_done = 1'b0;
    w_err  = 1'b0;
    if (r_state != S_IDLE && !w_fall && r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      w_next = S_IDLE;
      w_cnt  = 3'd0;
      w_err  = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          w_next = w_dat ? S_IDLE : S_DATA;
          w_cnt  = 3'd0;
          w_err  = w_dat;
        end
        S_DATA: begin
          w_sh   = {w_dat, r_sh[7:1]};
          w_cnt  = r_cnt + 3'd1;
          w_next = (r_cnt == 3'd7) ? S_PARITY : S_DATA;
        end
        S_PARITY: begin
          w_par  = w_dat;
          w_next = S_STOP;
        end
        default: begin
          w_next = S_IDLE;
          w_done = w_dat && w_par_ok;
          w_err  = !(w_dat && w_par_ok);
        end
      endcase
    end
    w_tmo = (r_state == S_IDLE || w_fall) ? '0 : r_tmo + TW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_par      <= 1'b0;
      r_tmo      <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_sh       <= w_sh;
      r_par      <= w_par;
      r_tmo      <= w_tmo;
      r_byte     <= r_sh;
      r_byte_vld <= w_done;
      frame_err  <= w_err;
    end
  end
  function automatic logic [7:0] f_map(input logic [7:0] c, input logic e, input logic s);
    logic [7:0] l;
    l = 8'd0;
    if (e) begin
      case (c)
        8'h6B: l = 8'd130;
        8'h75: l = 8'd131;
        8'h74: l = 8'd132;
        8'h72: l = 8'd133;
        8'h6C: l = 8'd134;
        8'h69: l = 8'd135;
        8'h7D: l = 8'd136;
        8'h7A: l = 8'd137;
        8'h70: l = 8'd138;
        8'h71: l = 8'd139;
        default: l = 8'd0;
      endcase
    end else begin
      case (c)
        8'h1C: l = 8'd97;  8'h32: l = 8'd98;  8'h21: l = 8'd99;  8'h23: l = 8'd100;
        8'h24: l = 8'd101; 8'h2B: l = 8'd102; 8'h34: l = 8'd103; 8'h33: l = 8'd104;
        8'h43: l = 8'd105; 8'h3B: l = 8'd106; 8'h42: l = 8'd107; 8'h4B: l = 8'd108;
        8'h3A: l = 8'd109; 8'h31: l = 8'd110; 8'h44: l = 8'd111; 8'h4D: l = 8'd112;
        8'h15: l = 8'd113; 8'h2D: l = 8'd114; 8'h1B: l = 8'd115; 8'h2C: l = 8'd116;
        8'h3C: l = 8'd117; 8'h2A: l = 8'd118; 8'h1D: l = 8'd119; 8'h22: l = 8'd120;
        8'h35: l = 8'd121; 8'h1A: l = 8'd122;
        8'h45: l = 8'd48;  8'h16: l = 8'd49;  8'h1E: l = 8'd50;  8'h26: l = 8'd51;
        8'h25: l = 8'd52;  8'h2E: l = 8'd53;  8'h36: l = 8'd54;  8'h3D: l = 8'd55;
        8'h3E: l = 8'd56;  8'h46: l = 8'd57;
        8'h29: l = 8'd32;  8'h5A: l = 8'd128; 8'h66: l = 8'd129; 8'h76: l = 8'd140;
        8'h05: l = 8'd141; 8'h06: l = 8'd142; 8'h04: l = 8'd143; 8'h0C: l = 8'd144;
        8'h03: l = 8'd145; 8'h0B: l = 8'd146; 8'h83: l = 8'd147; 8'h0A: l = 8'd148;
        8'h01: l = 8'd149; 8'h09: l = 8'd150; 8'h78: l = 8'd151; 8'h07: l = 8'd152;
        default: l = 8'd0;
      endcase
    end
    // shift only affects letters: upper case sits 32 below lower case
    return (s && l >= 8'd97 && l <= 8'd122) ? l - 8'd32 : l;
  endfunction
  assign w_code = f_map(r_byte, r_ext, r_shl | r_shr);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out     <= '0;
      key_valid <= 1'b0;
      r_shl     <= 1'b0;
      r_shr     <= 1'b0;
      r_brk     <= 1'b0;
      r_ext     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (r_byte_vld) begin
        if (r_byte == 8'hE0) r_ext <= 1'b1;
        else if (r_byte == 8'hF0) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (r_byte == 8'h12) r_shl <= !r_brk;
          else if (r_byte == 8'h59) r_shr <= !r_brk;
          // a break only clears out if it releases the key currently shown
          else if (w_code != 8'd0 && (!r_brk || w_code == r_out)) begin
            r_out     <= r_brk ? 8'd0 : w_code;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_keycode_writer.sv
// tb_ps2_keycode_writer: directed plus randomized PS/2 frames checked against a table-driven key model.
module tb_ps2_keycode_writer;
  localparam int H = 10;
  localparam int TMO = 300;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
    8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] FK [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
    8'h09, 8'h78, 8'h07};
  localparam logic [7:0] EX [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
  localparam logic [7:0] POOL [16] = '{8'h1C, 8'h32, 8'h1A, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h76,
    8'h05, 8'h07, 8'h83, 8'h11, 8'h75, 8'h4D, 8'h3E};
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [15:0] out;
  logic key_valid, frame_err;
  int total = 0, bad = 0, cyc = 0, kv_cnt = 0, fe_cnt = 0, kv_cyc = 0, fall_cyc = 0, e_kv = 0, e_fe = 0;
  logic [15:0] m_out = 16'd0;
  bit m_shl, m_shr, m_brk, m_ext;
  ps2_keycode_writer #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out(out), .key_valid(key_valid), .frame_err(frame_err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      kv_cnt <= kv_cnt + 1;
      kv_cyc <= cyc;
    end
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pbit(input logic d);
    ps2_data = d;
    cyc_n(H);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    cyc_n(H);
    ps2_clk = 1'b1;
  endtask
  task automatic partial(input logic [7:0] b, input int n);
    pbit(1'b0);
    for (int i = 0; i < n; i++) pbit(b[i]);
  endtask
  function automatic logic [15:0] m_map(input logic [7:0] c, input bit e, input bit s);
    if (e) begin
      for (int i = 0; i < 10; i++) if (EX[i] == c) return 16'(130 + i);
      return 16'd0;
    end
    for (int i = 0; i < 26; i++) if (LET[i] == c) return 16'((s ? 65 : 97) + i);
    for (int i = 0; i < 10; i++) if (DIG[i] == c) return 16'(48 + i);
    for (int i = 0; i < 12; i++) if (FK[i] == c) return 16'(141 + i);
    if (c == 8'h29) return 16'd32;
    if (c == 8'h5A) return 16'd128;
    if (c == 8'h66) return 16'd129;
    if (c == 8'h76) return 16'd140;
    return 16'd0;
  endfunction
  task automatic m_byte(input logic [7:0] b);
    logic [15:0] code;
    code = m_map(b, m_ext, m_shl || m_shr);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (b == 8'h12) m_shl = !m_brk;
      else if (b == 8'h59) m_shr = !m_brk;
      else if (code != 0 && !m_brk) begin
        m_out = code;
        e_kv++;
      end else if (code != 0 && code == m_out) begin
        m_out = 16'd0;
        e_kv++;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask
  task automatic m_reset();
    m_out = 16'd0;
    m_shl = 1'b0;
    m_shr = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask
  task automatic chk_all(input string tag);
    chk({tag, " out"}, out, m_out);
    chk({tag, " key_valid pulses"}, kv_cnt, e_kv);
    chk({tag, " frame_err pulses"}, fe_cnt, e_fe);
  endtask
  task automatic frame(input logic [7:0] b, input logic stp, input logic bp);
    pbit(1'b0);
    for (int i = 0; i < 8; i++) pbit(b[i]);
    pbit(~^b ^ bp);
    pbit(stp);
    cyc_n(H);
    if (!stp || (bp && PAR_EN)) e_fe++;
    else m_byte(b);
    chk_all($sformatf("byte %02h stop=%0b badpar=%0b", b, stp, bp));
  endtask
  task automatic key(input logic [7:0] b);
    frame(b, 1'b1, 1'b0);
  endtask
  initial begin
    logic [7:0] k, lk;
    bit e, le;
    int op;
    lk = 8'h1C;
    le = 1'b0;
    m_reset();
    cyc_n(3);
    chk("reset out", out, 16'd0);
    chk("reset key_valid", key_valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    reset = 1'b0;
    cyc_n(5);
    key(8'h1C);
    chk("make a key_valid latency", ((kv_cyc - fall_cyc) >= 4 && (kv_cyc - fall_cyc) <= 12) ? 1 : 0, 1);
    key(8'hF0);
    key(8'h1C);
    key(8'h12); key(8'h1C);
    key(8'hF0); key(8'h1C);
    key(8'hF0); key(8'h12); key(8'h1C);
    key(8'hF0); key(8'h1C);
    key(8'hE0); key(8'h75);
    key(8'hE0); key(8'hF0); key(8'h75);
    key(8'h75);
    key(8'h5A);
    frame(8'h5A, 1'b0, 1'b0);
    key(8'hF0); key(8'h5A);
    pbit(1'b1);
    cyc_n(H);
    e_fe++;
    chk_all("start bit high");
    partial(8'h5A, 3);
    cyc_n(TMO - 40);
    chk("no early timeout", fe_cnt, e_fe);
    cyc_n(60);
    e_fe++;
    chk_all("timeout");
    key(8'h5A);
    key(8'hF0); key(8'h5A);
    frame(8'h1C, 1'b1, 1'b1);
    key(8'hF0); key(8'h1C);
    key(8'h1C);
    partial(8'h1C, 4);
    reset = 1'b1;
    cyc_n(2);
    chk("out in reset", out, 16'd0);
    reset = 1'b0;
    m_reset();
    cyc_n(H);
    chk_all("after mid-frame reset");
    key(8'h29);
    key(8'hF0); key(8'h29);
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 9));
      e = ($urandom_range(0, 3) == 0);
      k = e ? EX[$urandom_range(0, 9)] : POOL[$urandom_range(0, 15)];
      if (op <= 3) begin
        if (e) key(8'hE0);
        key(k);
        lk = k;
        le = e;
      end else if (op <= 5) begin
        if (e) key(8'hE0);
        key(8'hF0);
        key(k);
      end else if (op == 6) begin
        if ($urandom_range(0, 1) == 1) key(8'hF0);
        key(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
      end else if (op == 7) begin
        if (le) key(8'hE0);
        key(8'hF0);
        key(lk);
      end else if (op == 8) begin
        frame(8'($urandom), 1'b0, 1'b0);
      end else begin
        partial(8'($urandom), int'($urandom_range(1, 7)));
        cyc_n(TMO + 20);
        e_fe++;
        chk_all("random timeout");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_keycode_writer.md
Name: ps2_keycode_writer

Overview:
- Producer end of the Hack keyboard path: decodes a PS/2 keyboard serial stream (scan code set 2) into a 16-bit Hack key code, as read by the CPU at KBD (0x6000).
- Holds the code of the currently pressed key and drives 0 when no key is pressed.
- Sits between the board's PS/2 pins and the keyboard memory-map register.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ps2_clk/ps2_data; legal range 2..4.
- FILTER_LEN, 4, consecutive equal synchronized ps2_clk samples required before accepting a level change (glitch filter).
- TIMEOUT_CYCLES, 50000, clk cycles without a filtered ps2_clk falling edge mid-frame before the frame is abandoned.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from pin, asynchronous.
- ps2_data  input  1  raw PS/2 data from pin, asynchronous.
- out  output  16  Hack key code of the held key; 0 = none.
- key_valid  output  1  one-cycle pulse when out changes due to a make or break.
- frame_err  output  1  one-cycle pulse on framing/timeout (and parity, if enabled) error.

Behaviour:
- Reset: synchronous, active-high. On reset, out=0, key_valid=0, frame_err=0, FSM=IDLE, shift_l=shift_r=0, break_pend=ext_pend=0, bit counter=0, synchronizers and filter preloaded to 1 (idle bus). Reset mid-frame discards the partial byte.
- Input conditioning: SYNC_STAGES synchronizer, then FILTER_LEN filter on ps2_clk. Sample event = filtered ps2_clk 1->0 transition; ps2_data is sampled in that same cycle.
- Frame FSM, advancing only on sample events:
  - IDLE: data=0 -> DATA with cnt=0; data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: data=1 -> byte complete and return to IDLE; data=0 -> pulse frame_err, drop the byte, return to IDLE.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES clk cycles with no sample event -> IDLE, pulse frame_err, clear cnt.
- Byte decoder: acts in the cycle after the byte completes, so out and key_valid are registered one cycle after the stop-bit sample event.
  - 0xE0: set ext_pend.
  - 0xF0: set break_pend.
  - 0x12 / 0x59: set shift_l / shift_r to !break_pend. out is unchanged and there is no key_valid.
  - Any other code: look up the Hack code using ext_pend and shift = shift_l|shift_r.
    - Make: if the mapped code is nonzero, out = code and pulse key_valid.
    - Break: if the mapped code equals out, out=0 and pulse key_valid; otherwise no change.
    - Clear ext_pend and break_pend afterwards.
  - Unmapped codes leave out unchanged, produce no key_valid, and clear both pend flags.
  - Typematic repeat makes rewrite the same value; key_valid still pulses.
- Mapping, bits 15:8 always 0:
  - Letters: a-z -> 97..122 unshifted, 65..90 shifted.
  - Digits: 0-9 -> 48..57 (shifted symbols not required; shift ignored).
  - Fixed keys: space=32, enter (0x5A)=128, backspace (0x66)=129, esc (0x76)=140.
  - Extended (E0 prefix): left 0x6B=130, up 0x75=131, right 0x74=132, down 0x72=133, home 0x6C=134, end 0x69=135, pgup 0x7D=136, pgdn 0x7A=137, insert 0x70=138, delete 0x71=139.
  - F1..F12 -> 141..152.
- Simultaneous events: a reset in the same cycle as a byte completion wins. A new sample event while the decoder is acting is legal; the decoder is single-cycle and cannot back-pressure.

Optional Feature:
- PS2_PARITY_CHECK_EN.
- Defined: STOP-state acceptance also requires odd parity over the 8 data bits plus the parity bit. On mismatch, pulse frame_err and drop the byte; out and the pend flags are untouched.
- Undefined: the parity bit is captured and ignored.

Test Plan:
- Make/break: frames 0x1C, then 0xF0, 0x1C -> out=97 with key_valid one cycle after the first stop bit; then out=0 with one key_valid pulse. No key_valid for the 0xF0 byte.
- Shift: 0x12, 0x1C, 0xF0 0x1C, 0xF0 0x12, 0x1C -> out=65, 0, then 97.
- Extended: 0xE0 0x75 -> out=131. Then 0xE0 0xF0 0x75 -> out=0. Bare 0x75 (keypad 8) -> no change, no key_valid.
- Errors: stop bit=0 on 0x5A -> frame_err pulse, out unchanged. A frame stalled after 3 data bits for TIMEOUT_CYCLES+1 -> frame_err, and the next clean 0x5A gives out=128.
- Parity (with PS2_PARITY_CHECK_EN): 0x1C with even parity -> frame_err, out stays 0. Without the macro -> out=97.
- Reset mid-frame: assert reset after 4 data bits of 0x1C -> out=0, FSM=IDLE; a following clean 0x29 gives out=32.
